// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - start-triggered up/down sweep counter with one-shot or auto-reload runs
module sweep_counter #(
  parameter int WIDTH  = 17,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              enable,
  input  logic              mode_cont,
  input  logic              dir_down,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  output logic              counting,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              wrap,
  output logic              last
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              mode_q, mode_d;
  logic              dir_q, dir_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;

  logic [WIDTH:0]    step_ext;
  logic [WIDTH:0]    up_sum;
  logic [WIDTH-1:0]  step_w;
  logic [WIDTH-1:0]  start_val;
  logic [WIDTH-1:0]  reload_val;
  logic              terminal;

  // The up-count sum keeps a carry bit so a large step near the top of the range cannot wrap.
  assign step_ext   = {{(WIDTH + 1 - STEP_W){1'b0}}, step_q};
  assign step_w     = step_ext[WIDTH-1:0];
  assign up_sum     = {1'b0, result_q} + step_ext;
  assign terminal   = dir_q ? ({1'b0, result_q} < step_ext) : (up_sum >= {1'b0, limit_q});
  assign start_val  = dir_down ? (limit - ONE) : '0;
  assign reload_val = dir_q ? (limit_q - ONE) : '0;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    limit_d  = limit_q;
    step_d   = step_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;

    if (state_q == RUN && stop) begin
      state_d  = IDLE;
      result_d = '0;
    end else if (start) begin
      limit_d = limit;
      step_d  = (step == '0) ? STEP_ONE : step;
      mode_d  = mode_cont;
      dir_d   = dir_down;
      if (limit == '0) begin
        state_d  = IDLE;
        result_d = '0;
        done_d   = 1'b1;
      end else begin
        state_d  = RUN;
        result_d = start_val;
      end
    end else if (state_q == RUN && enable) begin
      if (terminal) begin
        if (mode_q) begin
          result_d = reload_val;
          wrap_d   = 1'b1;
        end else begin
          state_d  = IDLE;
          result_d = '0;
          done_d   = 1'b1;
        end
      end else begin
        result_d = dir_q ? (result_q - step_w) : (result_q + step_w);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      result_q <= '0;
      limit_q  <= '0;
      step_q   <= '0;
      mode_q   <= 1'b0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      limit_q  <= limit_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  assign counting = (state_q == RUN);
  assign result   = result_q;
  assign done     = done_q;
  assign wrap     = wrap_q;
  assign last     = (state_q == RUN) && terminal;

endmodule

// File: doc/sweep_counter.md
Name: sweep_counter

Overview:
Parametrised start-triggered counter for VGA test-pattern and timing sweeps. It generalises the team's fixed 17-bit, 0-to-limit counter with the following additions:
- configurable width and step
- up or down direction
- one-shot or continuous (auto-reload) mode
- pause, abort and restart
- done/wrap pulses

It sits between the test-sequencer FSM and the pixel/address generators.

Parameters:
WIDTH, 17, width of limit and result.
STEP_W, 4, width of the step input.

Ports:
clk  input  1  system clock, all logic on rising edge.
resetn  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; latches configuration and (re)starts a run.
stop  input  1  single-cycle pulse; aborts the current run.
enable  input  1  advance qualifier; 0 holds result while running.
mode_cont  input  1  latched at start; 1 = continuous (auto-reload), 0 = one-shot.
dir_down  input  1  latched at start; 1 = count down, 0 = count up.
limit  input  WIDTH  number of positions, latched at start.
step  input  STEP_W  increment, latched at start; 0 is treated as 1.
counting  output  1  high while in RUN.
result  output  WIDTH  current count.
done  output  1  one-cycle pulse when a one-shot run completes.
wrap  output  1  one-cycle pulse when a continuous run reloads.
last  output  1  combinational; high when counting=1 and the next advance is terminal.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; counting=0, result=0, done=0, wrap=0.
  - Latched registers are cleared.
- States: IDLE and RUN. done and wrap default to 0 every cycle.
- Latched step: step_q = (step==0) ? 1 : step.
- Event priority each cycle: stop > start > advance.
- IDLE, start=1:
  - Latch limit_q, step_q, mode_q and dir_q.
  - If limit==0: next cycle done=1, stay IDLE, result=0, counting=0.
  - Otherwise: next cycle state=RUN, counting=1. result=0 when up; result=limit-1 when down.
- IDLE, no start: all outputs hold (result=0). stop is ignored.
- RUN, stop=1: next cycle state=IDLE, counting=0, result=0. No done, no wrap.
- RUN, start=1 (restart): relatch all configuration and reload the start value exactly as from IDLE. state stays RUN, counting stays 1, no done. If the new limit==0, go to IDLE with done=1.
- RUN, enable=1 (advance):
  - Up direction: terminal when result + step_q >= limit_q. Compute in WIDTH+1 bits; no overflow wrap is permitted.
  - Down direction: terminal when result < step_q.
  - Non-terminal: result <= result ± step_q.
  - Terminal, one-shot: next cycle result=0, counting=0, done=1, state=IDLE.
  - Terminal, continuous: next cycle result=start value (0 when up, limit_q-1 when down), wrap=1, stay RUN.
- RUN, enable=0: result holds. last still reflects the pending terminal condition.
- Latency:
  - start to first result: 1 cycle. The first value is held for at least one cycle.
  - Terminal advance to done/wrap: 1 cycle (same edge as the reload).
- Number of result values visited per pass = ceil(limit/step_q). With enable tied high, a one-shot run lasts exactly ceil(limit/step_q) cycles with counting=1.
- limit==1: a single value (0); terminal on the first advance.
- limit and step inputs are ignored except in a start cycle. A mid-run change of these inputs has no effect.
- Reset asserted mid-run: immediately forces the reset values. No done pulse.

Test Plan:
1. Up, one-shot, WIDTH=17, limit=5, step=1, enable=1: pulse start at cycle 0 -> result 0,1,2,3,4 on cycles 1-5 with counting=1; cycle 6 result=0, counting=0, done=1 for exactly one cycle; last=1 only on cycle 5.
2. Up, continuous, limit=10, step=3: start -> result 0,3,6,9,0,3…; wrap=1 on each return to 0; counting stays 1; done is never asserted; stop on a cycle with result=6 -> next cycle counting=0, result=0, no done.
3. Down, one-shot, limit=8, step=2: start -> result 7,5,3,1, then result=0, counting=0, done=1; step=0 with limit=3 -> result 2,1,0 then done.
4. Pause and restart: up, limit=100, step=1; drop enable at result=40 for 5 cycles -> result stays 40; raise enable -> 41; pulse start with limit=4 -> next cycle result=0, counting=1, no done; the run then ends after 4 values.
5. Edges: start with limit=0 -> done=1 next cycle, counting stays 0. Limit=1 -> one cycle of result=0, then done. Limit=131071, step=15, up: no overflow, terminal at result=131070 (the largest multiple of 15 below 131071). resetn low mid-run -> counting=0, result=0 asynchronously, no done.
6. Simultaneous events: start and stop in the same RUN cycle -> stop wins (IDLE, result=0). start and a terminal advance together in one-shot mode -> restart wins, no done.
